// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port among N_REQ writeback
// requesters (ALU, load unit, special-register writer). A round-robin
// pointer selects which valid requester is granted. The accepted command is
// registered and drives the register file during the following cycle.
//
// Parameters
//   N_REQ  number of requesters (2..4)
//   AW     write address width; the register file holds 16 entries, so the
//          top address bit must be 0 for a mode-00 write
//   DW     data width
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   i_req_valid  per-requester write pending
//   o_req_ready  one-hot combinational grant (transfer on valid & ready)
//   i_req_addr   per-requester destination, slice i = [i*AW +: AW]
//   i_req_data   per-requester write data, slice i = [i*DW +: DW]
//   i_req_mode   per-requester mode: 00 full write, 01 r10[31:16],
//                10 r10[15:0], 11 full r11
//   i_rf_stall   blocks all grants this cycle
//   o_rf_we      register file write enable
//   o_rf_addr    register file write address (addr_wr_dest)
//   o_rf_data    register file write data (data_in)
//   o_rf_ctrl    register file write control (control_rf)
//   o_err_addr   sticky: a mode-00 request with the top address bit set
//                was accepted
//   o_busy       any request pending or a write in flight
//   i_rd_addr    read addresses s,t,d (slice 0 = s), forwarding only
//   o_fwd_hit    per read port: address matches the in-flight write
//
// Optional feature macro: RF_ARB_FWD_EN
//   defined   -> o_fwd_hit compares the in-flight write target against
//                each read address
//   undefined -> o_fwd_hit is tied to 0 and i_rd_addr is ignored
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    i_req_valid,
    output logic [N_REQ-1:0]    o_req_ready,
    input  logic [N_REQ*AW-1:0] i_req_addr,
    input  logic [N_REQ*DW-1:0] i_req_data,
    input  logic [N_REQ*2-1:0]  i_req_mode,
    input  logic                i_rf_stall,
    output logic                o_rf_we,
    output logic [AW-1:0]       o_rf_addr,
    output logic [DW-1:0]       o_rf_data,
    output logic [1:0]          o_rf_ctrl,
    output logic                o_err_addr,
    output logic                o_busy,
    input  logic [3*AW-1:0]     i_rd_addr,
    output logic [2:0]          o_fwd_hit
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = PW + 1;

    // Round-robin pointer and registered write command
    logic [PW-1:0] r_rr_ptr;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_addr;
    logic [DW-1:0] r_rf_data;
    logic [1:0]    r_rf_ctrl;
    logic          r_err_addr;

    // Arbitration results
    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_accept;
    logic [SW-1:0]    w_scan_sum;
    logic [PW-1:0]    w_scan_idx;
    logic [PW-1:0]    w_ptr_nxt;

    // Selected requester fields
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    logic [1:0]    w_sel_mode;
    logic          w_sel_bad;

    // Scan from the pointer upward (modulo N_REQ) and grant the first valid requester
    always_comb begin
        w_grant    = '0;
        w_gnt_idx  = '0;
        w_accept   = 1'b0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        if (reset || i_rf_stall) begin
            w_accept = 1'b0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                w_scan_sum = {1'b0, r_rr_ptr} + SW'(k);
                if (w_scan_sum >= SW'(N_REQ)) begin
                    w_scan_sum = w_scan_sum - SW'(N_REQ);
                end else begin
                    w_scan_sum = w_scan_sum;
                end
                w_scan_idx = w_scan_sum[PW-1:0];
                if (!w_accept && i_req_valid[w_scan_idx]) begin
                    w_accept  = 1'b1;
                    w_gnt_idx = w_scan_idx;
                end else begin
                    w_accept  = w_accept;
                end
            end
            w_grant[w_gnt_idx] = w_accept;
        end
    end

    // Pointer moves to the slot after the accepted requester
    always_comb begin
        if (w_gnt_idx == PW'(N_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_idx + PW'(1);
        end
    end

    // AND-OR mux of the granted requester's command (grant is one-hot)
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_mode = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_addr = w_sel_addr | ({AW{w_grant[i]}} & i_req_addr[i*AW +: AW]);
            w_sel_data = w_sel_data | ({DW{w_grant[i]}} & i_req_data[i*DW +: DW]);
            w_sel_mode = w_sel_mode | ({2{w_grant[i]}}  & i_req_mode[i*2 +: 2]);
        end
        // Only full writes use the address; r10/r11 modes ignore it entirely
        w_sel_bad = (w_sel_mode == 2'b00) && w_sel_addr[AW-1];
    end

    // Pointer, output command stage and sticky address error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
            r_rf_ctrl  <= 2'b00;
            r_err_addr <= 1'b0;
        end else if (w_accept) begin
            // A bad full-write is still consumed, but its slot writes nothing
            r_rr_ptr   <= w_ptr_nxt;
            r_rf_we    <= !w_sel_bad;
            r_rf_addr  <= w_sel_addr;
            r_rf_data  <= w_sel_data;
            r_rf_ctrl  <= w_sel_mode;
            r_err_addr <= r_err_addr | w_sel_bad;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign o_req_ready = w_grant;
    assign o_rf_we     = r_rf_we;
    assign o_rf_addr   = r_rf_addr;
    assign o_rf_data   = r_rf_data;
    assign o_rf_ctrl   = r_rf_ctrl;
    assign o_err_addr  = r_err_addr;
    assign o_busy      = (|i_req_valid) | r_rf_we;

`ifdef RF_ARB_FWD_EN
    logic [AW-1:0] w_fwd_tgt;
    logic [2:0]    w_fwd_hit;

    // Register actually written by the in-flight command
    always_comb begin
        case (r_rf_ctrl)
            2'b00:   w_fwd_tgt = r_rf_addr;
            2'b01:   w_fwd_tgt = AW'(10);
            2'b10:   w_fwd_tgt = AW'(10);
            2'b11:   w_fwd_tgt = AW'(11);
            default: w_fwd_tgt = r_rf_addr;
        endcase
    end

    // Compare each read port against the in-flight target
    always_comb begin
        w_fwd_hit = 3'b000;
        for (int j = 0; j < 3; j++) begin
            if (r_rf_we && (i_rd_addr[j*AW +: AW] == w_fwd_tgt)) begin
                w_fwd_hit[j] = 1'b1;
            end else begin
                w_fwd_hit[j] = 1'b0;
            end
        end
    end

    assign o_fwd_hit = w_fwd_hit;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^i_rd_addr;
    assign o_fwd_hit        = 3'b000;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Table-driven bench for rf_write_arbiter (N_REQ=3, AW=5, DW=32). Each row
// gives the requester inputs and the grant expected from a hand-worked
// round-robin trace. Accepted commands are pushed to a scoreboard and popped
// one cycle later to check the register-file port. A hand-written sequence
// covers reset asserted in the middle of a cycle.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [5:0]  req_mode;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  rf_ctrl;
    logic        err_addr;
    logic        busy;
    logic [14:0] rd_addr;
    logic [2:0]  fwd_hit;

    rf_write_arbiter #(.N_REQ(3), .AW(5), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_req_mode  (req_mode),
        .i_rf_stall  (rf_stall),
        .o_rf_we     (rf_we),
        .o_rf_addr   (rf_addr),
        .o_rf_data   (rf_data),
        .o_rf_ctrl   (rf_ctrl),
        .o_err_addr  (err_addr),
        .o_busy      (busy),
        .i_rd_addr   (rd_addr),
        .o_fwd_hit   (fwd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic        stall;
        logic [2:0]  ready;
        logic [14:0] addr;
        logic [95:0] data;
        logic [5:0]  mode;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  ctrl;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic exp_err = 1'b0;
    int   part1_rows;

    localparam logic [14:0] ROT_A = {5'h1F, 5'd2, 5'd1};
    localparam logic [95:0] ROT_D = {32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [5:0]  ROT_M = {2'b10, 2'b11, 2'b00};

    function automatic vec_t mkv(input logic [2:0] valid, input logic stall,
                                 input logic [2:0] ready, input logic [14:0] addr,
                                 input logic [95:0] data, input logic [5:0] mode);
        vec_t v;
        v.valid = valid;
        v.stall = stall;
        v.ready = ready;
        v.addr  = addr;
        v.data  = data;
        v.mode  = mode;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef RF_ARB_FWD_EN
    function automatic logic [2:0] fwd_model(input exp_t e, input logic [14:0] rd);
        logic [2:0] h;
        logic [4:0] tgt;
        if (e.ctrl == 2'b00) tgt = e.addr;
        else if (e.ctrl == 2'b11) tgt = 5'd11;
        else tgt = 5'd10;
        for (int j = 0; j < 3; j++) h[j] = e.we && (rd[j*5 +: 5] == tgt);
        return h;
    endfunction
`endif

    task automatic run_row(input vec_t v, input int idx);
        exp_t       e;
        exp_t       n;
        logic [2:0] acc;
        logic [2:0] efwd;
        @(posedge clk);
        #1;
        req_valid = v.valid;
        req_addr  = v.addr;
        req_data  = v.data;
        req_mode  = v.mode;
        rf_stall  = v.stall;
        @(negedge clk);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        chk($sformatf("ready[%0d]", idx), 64'(req_ready), 64'(v.ready));
        chk($sformatf("rf_we[%0d]", idx), 64'(rf_we), 64'(e.we));
        chk($sformatf("busy[%0d]", idx), 64'(busy), 64'((|v.valid) | e.we));
        chk($sformatf("err[%0d]", idx), 64'(err_addr), 64'(exp_err));
        if (e.we) begin
            chk($sformatf("rf_addr[%0d]", idx), 64'(rf_addr), 64'(e.addr));
            chk($sformatf("rf_data[%0d]", idx), 64'(rf_data), 64'(e.data));
            chk($sformatf("rf_ctrl[%0d]", idx), 64'(rf_ctrl), 64'(e.ctrl));
        end
`ifdef RF_ARB_FWD_EN
        efwd = fwd_model(e, rd_addr);
`else
        efwd = 3'b000;
`endif
        chk($sformatf("fwd_hit[%0d]", idx), 64'(fwd_hit), 64'(efwd));
        // Model the command the DUT should register at the coming edge
        acc = v.valid & v.ready;
        n   = '0;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                n.addr = v.addr[i*5 +: 5];
                n.data = v.data[i*32 +: 32];
                n.ctrl = v.mode[i*2 +: 2];
                if (n.ctrl == 2'b00 && n.addr[4]) exp_err = 1'b1;
                else n.we = 1'b1;
            end
        end
        sb.push_back(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
        req_mode  = '0;
        rf_stall  = 1'b0;
        rd_addr   = {5'd11, 5'd3, 5'd10};

        // Rotation with all requesters valid, starting from pointer 0
        tbl.push_back(mkv(3'b111, 1'b0, 3'b001, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b010, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b100, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b001, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b010, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b100, ROT_A, ROT_D, ROT_M));
        // Stall mid-stream: no grant, in-flight write still shows
        tbl.push_back(mkv(3'b111, 1'b1, 3'b000, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b111, 1'b0, 3'b001, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b110, 1'b0, 3'b010, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b100, 1'b0, 3'b100, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        // Single full write from requester 0
        tbl.push_back(mkv(3'b001, 1'b0, 3'b001, 15'd5, {64'h0, 32'hDEADBEEF}, 6'b000000));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        // Requester 1 held off by a 3-cycle stall
        tbl.push_back(mkv(3'b010, 1'b1, 3'b000, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hCAFEF00D, 32'h0}, 6'b000000));
        tbl.push_back(mkv(3'b010, 1'b1, 3'b000, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hCAFEF00D, 32'h0}, 6'b000000));
        tbl.push_back(mkv(3'b010, 1'b1, 3'b000, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hCAFEF00D, 32'h0}, 6'b000000));
        tbl.push_back(mkv(3'b010, 1'b0, 3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hCAFEF00D, 32'h0}, 6'b000000));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        // Out-of-range full write from requester 2: consumed, not written
        tbl.push_back(mkv(3'b100, 1'b0, 3'b100, {5'h13, 5'd0, 5'd0}, {32'h0BADDA7A, 64'h0}, 6'b000000));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        // Requester 1 mode 01 (r10 upper half), observed by read port s
        tbl.push_back(mkv(3'b010, 1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h12345678, 32'h0}, 6'b000100));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        // Pointer at 2: requester 2 wins over requester 0, then 0 follows
        tbl.push_back(mkv(3'b101, 1'b0, 3'b100, {5'd11, 5'd0, 5'd4}, {32'hAAAA5555, 32'h0, 32'h5555AAAA}, 6'b000000));
        tbl.push_back(mkv(3'b001, 1'b0, 3'b001, {5'd11, 5'd0, 5'd4}, {32'hAAAA5555, 32'h0, 32'h5555AAAA}, 6'b000000));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        part1_rows = tbl.size();
        // After a mid-cycle reset the pointer restarts at 0
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        tbl.push_back(mkv(3'b110, 1'b0, 3'b010, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b100, 1'b0, 3'b100, ROT_A, ROT_D, ROT_M));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));
        tbl.push_back(mkv(3'b000, 1'b0, 3'b000, '0, '0, '0));

        // Reset values while reset is held
        #3;
        chk("rst_ready", 64'(req_ready), 64'(3'b000));
        chk("rst_we",    64'(rf_we),     64'(1'b0));
        chk("rst_addr",  64'(rf_addr),   64'(5'd0));
        chk("rst_data",  64'(rf_data),   64'(32'd0));
        chk("rst_ctrl",  64'(rf_ctrl),   64'(2'b00));
        chk("rst_err",   64'(err_addr),  64'(1'b0));
        chk("rst_fwd",   64'(fwd_hit),   64'(3'b000));
        chk("rst_busy",  64'(busy),      64'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < part1_rows; r++) run_row(tbl[r], r);

        // Reset asserted mid-cycle while a write is in flight and all requesters wait
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        req_addr  = ROT_A;
        req_data  = ROT_D;
        req_mode  = ROT_M;
        rf_stall  = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_we_before_reset", 64'(rf_we), 64'(1'b1));
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(3'b000));
        chk("mid_rst_we",    64'(rf_we),     64'(1'b0));
        chk("mid_rst_addr",  64'(rf_addr),   64'(5'd0));
        chk("mid_rst_data",  64'(rf_data),   64'(32'd0));
        chk("mid_rst_ctrl",  64'(rf_ctrl),   64'(2'b00));
        chk("mid_rst_err",   64'(err_addr),  64'(1'b0));
        chk("mid_rst_fwd",   64'(fwd_hit),   64'(3'b000));
        chk("mid_rst_busy",  64'(busy),      64'(1'b1));
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 1'b0;
        sb.delete();

        for (int r = part1_rows; r < tbl.size(); r++) run_row(tbl[r], r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
